// File: rtl/ext_mem_pkg.sv
// Shared definitions for the external-memory host port.
// Defines:
//   op_e    - host command opcodes (IRAM write, DRAM write, DRAM read, reserved)
//   state_e - host port FSM states
//   ADDR_W_DEF / DATA_W_DEF - default address and data widths
//   PH_W    - width of the phase down-counter
package ext_mem_pkg;

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 16;
  localparam int PH_W       = 4;

  typedef enum logic [1:0] {
    OP_IRAM_WR = 2'b00,
    OP_DRAM_WR = 2'b01,
    OP_DRAM_RD = 2'b10,
    OP_RSVD    = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_RDWAIT,
    S_RUN
  } state_e;

endpackage

// File: rtl/ext_phase_timer.sv
// Loadable down-counter timing every timed FSM phase.
// Ports:
//   clock, reset_n - clock and async active-low reset
//   load, load_val - load the counter with (phase length - 1)
//   done           - counter has reached zero (last cycle of the phase)
// Holds at zero; never wraps.
module ext_phase_timer
  import ext_mem_pkg::*;
(
  input  logic            clock,
  input  logic            reset_n,
  input  logic            load,
  input  logic [PH_W-1:0] load_val,
  output logic            done
);

  logic [PH_W-1:0] cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)        cnt <= '0;
    else if (load)       cnt <= load_val;
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/ext_mem_host_port.sv
// External memory host port: turns host commands into the timed
// address/data/strobe/read-enable/phase signals used by the multicore top.
// Ports:
//   clock, reset_n            - clock, async active-low reset
//   cmd_valid/cmd_ready       - host command handshake (ready only in IDLE)
//   cmd_op/core/addr/wdata    - command fields
//   run_req                   - level request to run the processor
//   rsp_valid/rsp_data        - read response (pulse / held data)
//   err                       - pulse on bad command (or verify mismatch)
//   run_active                - mirrors start
//   addr_ext, data_in_ins, data_in_dram, iram_write_ext, dram_write_ext,
//   read_en_ext, dram_rdata   - memory side of the top
//   start, start_2/3/4        - phase flags: run, IRAM load, DRAM load, readback
// Build option: EXT_WRITE_VERIFY_EN adds a read-back check after each DRAM write.
module ext_mem_host_port
  import ext_mem_pkg::*;
#(
  parameter int NUM_CORES  = 8,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 4,
  parameter int READ_LAT   = 5
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [2:0]           cmd_core,
  input  logic [ADDR_W-1:0]    cmd_addr,
  input  logic [DATA_W-1:0]    cmd_wdata,
  input  logic                 run_req,
  output logic                 rsp_valid,
  output logic [DATA_W-1:0]    rsp_data,
  output logic                 err,
  output logic                 run_active,
  output logic [ADDR_W-1:0]    addr_ext,
  output logic [DATA_W-1:0]    data_in_ins,
  output logic [DATA_W-1:0]    data_in_dram,
  output logic [NUM_CORES-1:0] iram_write_ext,
  output logic                 dram_write_ext,
  output logic                 read_en_ext,
  input  logic [DATA_W-1:0]    dram_rdata,
  output logic                 start,
  output logic                 start_2,
  output logic                 start_3,
  output logic                 start_4
);

  localparam logic [PH_W-1:0]      SU_V = PH_W'(SETUP_CYC - 1);
  localparam logic [PH_W-1:0]      ST_V = PH_W'(STROBE_CYC - 1);
  localparam logic [PH_W-1:0]      HD_V = PH_W'(HOLD_CYC - 1);
  localparam logic [PH_W-1:0]      RD_V = PH_W'(READ_LAT - 1);
  localparam logic [NUM_CORES-1:0] ONE  = NUM_CORES'(1);

  state_e          state;
  op_e             op_q;
  logic [2:0]      core_q;
  logic            tmr_load;
  logic [PH_W-1:0] tmr_val;
  logic            tmr_done;
`ifdef EXT_WRITE_VERIFY_EN
  logic            verify_q;
`endif

  op_e         cmd_op_e;
  logic [31:0] core_w;
  logic        hs;
  logic        cmd_bad;

  assign cmd_op_e = op_e'(cmd_op);
  // Widen before comparing so the range check stays meaningful for any NUM_CORES.
  assign core_w   = 32'(cmd_core);
  assign hs       = cmd_valid & cmd_ready;
  assign cmd_bad  = (cmd_op_e == OP_RSVD) ||
                    ((cmd_op_e == OP_IRAM_WR) && (core_w >= 32'(NUM_CORES)));
  assign run_active = start;

  // Timer is reloaded on the same edge that enters each timed state.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      S_IDLE: if (hs && !cmd_bad) begin
        tmr_load = 1'b1;
        tmr_val  = (cmd_op_e == OP_DRAM_RD) ? RD_V : SU_V;
      end
      S_SETUP:  if (tmr_done) begin tmr_load = 1'b1; tmr_val = ST_V; end
      S_STROBE: if (tmr_done) begin tmr_load = 1'b1; tmr_val = HD_V; end
`ifdef EXT_WRITE_VERIFY_EN
      S_HOLD:   if (tmr_done && op_q == OP_DRAM_WR) begin
        tmr_load = 1'b1;
        tmr_val  = RD_V;
      end
`endif
      default: ;
    endcase
  end

  ext_phase_timer u_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      op_q           <= OP_IRAM_WR;
      core_q         <= '0;
      cmd_ready      <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
      err            <= 1'b0;
      addr_ext       <= '0;
      data_in_ins    <= '0;
      data_in_dram   <= '0;
      iram_write_ext <= '0;
      dram_write_ext <= 1'b0;
      read_en_ext    <= 1'b0;
      start          <= 1'b0;
      start_2        <= 1'b0;
      start_3        <= 1'b0;
      start_4        <= 1'b0;
`ifdef EXT_WRITE_VERIFY_EN
      verify_q       <= 1'b0;
`endif
    end else begin
      err       <= 1'b0;
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!cmd_ready) begin
            // First idle cycle out of reset: just raise ready.
            cmd_ready <= 1'b1;
          end else if (hs) begin
            if (cmd_bad) begin
              err <= 1'b1;
            end else begin
              op_q      <= cmd_op_e;
              core_q    <= cmd_core;
              addr_ext  <= cmd_addr;
              cmd_ready <= 1'b0;
              case (cmd_op_e)
                OP_IRAM_WR: begin
                  data_in_ins <= cmd_wdata;
                  start_2     <= 1'b1;
                  state       <= S_SETUP;
                end
                OP_DRAM_WR: begin
                  data_in_dram <= cmd_wdata;
                  start_3      <= 1'b1;
                  state        <= S_SETUP;
                end
                default: begin
                  read_en_ext <= 1'b1;
                  start_4     <= 1'b1;
                  state       <= S_RDWAIT;
                end
              endcase
            end
          end else if (run_req) begin
            // Commands take priority; run only starts on a cycle with no handshake.
            start     <= 1'b1;
            cmd_ready <= 1'b0;
            state     <= S_RUN;
          end
        end
        S_SETUP: if (tmr_done) begin
          if (op_q == OP_IRAM_WR) iram_write_ext <= ONE << core_q;
          else                    dram_write_ext <= 1'b1;
          state <= S_STROBE;
        end
        S_STROBE: if (tmr_done) begin
          iram_write_ext <= '0;
          dram_write_ext <= 1'b0;
          state          <= S_HOLD;
        end
        S_HOLD: if (tmr_done) begin
`ifdef EXT_WRITE_VERIFY_EN
          if (op_q == OP_DRAM_WR) begin
            verify_q    <= 1'b1;
            read_en_ext <= 1'b1;
            start_3     <= 1'b0;
            start_4     <= 1'b1;
            state       <= S_RDWAIT;
          end else begin
`else
          begin
`endif
            start_2   <= 1'b0;
            start_3   <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        S_RDWAIT: if (tmr_done) begin
          read_en_ext <= 1'b0;
          start_4     <= 1'b0;
          cmd_ready   <= 1'b1;
          state       <= S_IDLE;
`ifdef EXT_WRITE_VERIFY_EN
          if (verify_q) begin
            // Verify reads report only through err, never rsp_valid.
            verify_q <= 1'b0;
            err      <= (dram_rdata != data_in_dram);
          end else begin
`else
          begin
`endif
            rsp_data  <= dram_rdata;
            rsp_valid <= 1'b1;
          end
        end
        S_RUN: if (!run_req) begin
          start     <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ext_mem_host_port.sv
// Self-checking bench for ext_mem_host_port with a behavioural DRAM stub and
// a read-response scoreboard. Honours EXT_WRITE_VERIFY_EN when defined.
module tb_ext_mem_host_port;

`ifdef EXT_WRITE_VERIFY_EN
  localparam bit VFY = 1'b1;
`else
  localparam bit VFY = 1'b0;
`endif
  localparam int WR_OCC = 10;                  // setup+strobe+hold
  localparam int DW_OCC = VFY ? WR_OCC + 5 : WR_OCC;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [2:0]  cmd_core = '0;
  logic [8:0]  cmd_addr = '0;
  logic [15:0] cmd_wdata = '0;
  logic        run_req = 1'b0;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        err;
  logic        run_active;
  logic [8:0]  addr_ext;
  logic [15:0] data_in_ins;
  logic [15:0] data_in_dram;
  logic [7:0]  iram_write_ext;
  logic        dram_write_ext;
  logic        read_en_ext;
  logic [15:0] dram_rdata;
  logic        start, start_2, start_3, start_4;

  int checks = 0;
  int failures = 0;
  logic [15:0] sb[$];
  logic [15:0] mem [0:511];
  logic        stub_zero = 1'b0;

  always #5 clock = ~clock;

  ext_mem_host_port dut (
    .clock(clock), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_core(cmd_core), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .run_req(run_req), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .err(err), .run_active(run_active), .addr_ext(addr_ext),
    .data_in_ins(data_in_ins), .data_in_dram(data_in_dram),
    .iram_write_ext(iram_write_ext), .dram_write_ext(dram_write_ext),
    .read_en_ext(read_en_ext), .dram_rdata(dram_rdata),
    .start(start), .start_2(start_2), .start_3(start_3), .start_4(start_4)
  );

  // DRAM stub: writes on the strobe, asynchronous read of the current address.
  always @(posedge clock) if (dram_write_ext) mem[addr_ext] <= data_in_dram;
  assign dram_rdata = stub_zero ? 16'h0000 : mem[addr_ext];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every response must match the oldest outstanding read.
  always @(negedge clock) if (reset_n && rsp_valid) begin
    if (sb.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 0);
    else                chk("rsp_data", 32'(rsp_data), 32'(sb.pop_front()));
  end

  always @(negedge clock) if (reset_n)
    chk("phase_excl", 32'($countones({start, start_2, start_3, start_4}) <= 1), 1);

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic drive(input logic [1:0] op, input logic [2:0] core,
                       input logic [8:0] addr, input logic [15:0] wd);
    cmd_op = op; cmd_core = core; cmd_addr = addr; cmd_wdata = wd;
    cmd_valid = 1'b1;
  endtask

  // Call at a negedge; returns just after the accepting posedge.
  task automatic handshake(input string tag);
    int n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clock); n++; end
    if (!cmd_ready) chk(tag, 32'(cmd_ready), 1);
    @(posedge clock);
  endtask

  task automatic send(input logic [1:0] op, input logic [2:0] core,
                      input logic [8:0] addr, input logic [15:0] wd, input string tag);
    @(negedge clock);
    drive(op, core, addr, wd);
    handshake(tag);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clock);
    while (!cmd_ready && n < 100) begin @(negedge clock); n++; end
    chk(tag, 32'(cmd_ready), 1);
  endtask

  initial begin
    int strb;
    // Reset state
    #2;
    chk("rst_ready", 32'(cmd_ready), 0);
    chk("rst_strobes", 32'({iram_write_ext, dram_write_ext, read_en_ext}), 0);
    chk("rst_phase", 32'({start, start_2, start_3, start_4, run_active}), 0);
    chk("rst_addr", 32'(addr_ext), 0);
    @(negedge clock); @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rel_ready", 32'(cmd_ready), 1);

    // IRAM write core 5
    send(2'b00, 3'd5, 9'h001, 16'h1234, "iram_hs");
    for (int k = 1; k <= WR_OCC; k++) begin
      @(negedge clock);
      chk("iram_addr", 32'(addr_ext), 32'h001);
      chk("iram_data", 32'(data_in_ins), 32'h1234);
      chk("iram_strobe", 32'(iram_write_ext), (k >= 3 && k <= 6) ? 32'h20 : 32'h0);
      chk("iram_start2", 32'(start_2), 1);
      chk("iram_ready", 32'(cmd_ready), 0);
    end
    @(negedge clock);
    chk("iram_done_ready", 32'(cmd_ready), 1);
    chk("iram_done_start2", 32'(start_2), 0);

    // Reset mid-strobe
    send(2'b00, 3'd2, 9'h003, 16'h7777, "rst_hs");
    for (int k = 1; k <= 4; k++) @(negedge clock);
    chk("mid_strobe", 32'(iram_write_ext), 32'h04);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_strobe", 32'(iram_write_ext), 0);
    chk("abort_start2", 32'(start_2), 0);
    chk("abort_ready", 32'(cmd_ready), 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("abort_rel_ready", 32'(cmd_ready), 1);
    chk("abort_rel_strobe", 32'(iram_write_ext), 0);

    // Preload DRAM via a write, then read it back
    send(2'b01, 3'd0, 9'h040, 16'hBEEF, "pre_hs");
    wait_idle("pre_idle");
    sb.push_back(16'hBEEF);
    send(2'b10, 3'd0, 9'h040, 16'h0000, "rd_hs");
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      chk("rd_en", 32'(read_en_ext), 1);
      chk("rd_start4", 32'(start_4), 1);
      chk("rd_rsp_early", 32'(rsp_valid), 0);
    end
    @(negedge clock);
    chk("rd_rsp", 32'(rsp_valid), 1);
    chk("rd_en_off", 32'(read_en_ext), 0);
    chk("rd_start4_off", 32'(start_4), 0);
    @(negedge clock);
    chk("rd_rsp_pulse", 32'(rsp_valid), 0);
    chk("rd_hold", 32'(rsp_data), 32'hBEEF);

    // Back-to-back DRAM writes with cmd_valid held high
    @(negedge clock);
    for (int i = 1; i <= 4; i++) begin
      drive(2'b01, 3'd0, 9'(i), 16'(16'hA000 + i));
      handshake("b2b_hs");
      strb = 0;
      for (int k = 1; k <= DW_OCC; k++) begin
        @(negedge clock);
        chk("b2b_ready", 32'(cmd_ready), 0);
        chk("b2b_addr", 32'(addr_ext), 32'(i));
        if (k == 1) chk("b2b_data", 32'(data_in_dram), 32'(16'hA000 + i));
        if (dram_write_ext) strb++;
      end
      chk("b2b_strobe_cyc", 32'(strb), 4);
    end
    cmd_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      sb.push_back(16'(16'hA000 + i));
      send(2'b10, 3'd0, 9'(i), 16'h0000, "rb_hs");
      wait_idle("rb_idle");
    end

    // Run arbitration: command first, then RUN
    @(negedge clock);
    drive(2'b01, 3'd0, 9'h010, 16'h5555);
    run_req = 1'b1;
    handshake("arb_hs");
    #1 cmd_valid = 1'b0;
    for (int k = 1; k <= DW_OCC; k++) begin
      @(negedge clock);
      chk("arb_no_start", 32'(start), 0);
      if (k <= WR_OCC) chk("arb_start3", 32'(start_3), 1);
    end
    @(negedge clock);
    chk("arb_idle_ready", 32'(cmd_ready), 1);
    @(negedge clock);
    chk("run_start", 32'(start), 1);
    chk("run_active", 32'(run_active), 1);
    drive(2'b10, 3'd0, 9'h010, 16'h0000);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("run_ready", 32'(cmd_ready), 0);
      chk("run_hold", 32'(start), 1);
    end
    cmd_valid = 1'b0;
    run_req = 1'b0;
    @(negedge clock);
    chk("run_drop", 32'(start), 0);
    chk("run_drop_ready", 32'(cmd_ready), 1);

    // Reserved opcode
    send(2'b11, 3'd0, 9'h055, 16'hDEAD, "err_hs");
    @(negedge clock);
    chk("err_pulse", 32'(err), 1);
    chk("err_ready", 32'(cmd_ready), 1);
    chk("err_strobes", 32'({iram_write_ext, dram_write_ext, read_en_ext}), 0);
    chk("err_phase", 32'({start, start_2, start_3, start_4}), 0);
    @(negedge clock);
    chk("err_clear", 32'(err), 0);

    // Write verify against a DRAM that reads back zero
    stub_zero = 1'b1;
    send(2'b01, 3'd0, 9'h020, 16'h00FF, "vfy_hs");
    for (int k = 1; k <= DW_OCC; k++) @(negedge clock);
    chk("vfy_err_early", 32'(err), 0);
    @(negedge clock);
    chk("vfy_err", 32'(err), 32'(VFY));
    stub_zero = 1'b0;

    @(negedge clock);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
